conv_scheduler: RTL
===================

// Module: conv_scheduler
// PURPOSE
//  Sequences one full convolution job: reads image/kernel bytes from the feature and weight BRAMs and streams them tap-by-tap into the convolution engine.
//  Captures each MAC result and writes it to the output buffer, one result per output pixel.
//  Sits between the top-level job controller (start/done) and the convolution datapath.
//  Keeps exactly one output window in flight.
// PARAMETERS
//  ADDR_WIDTH  13  width of dimensions and memory addresses
//  DATA_WIDTH  8   image/weight element width; results are 2*DATA_WIDTH
//  MAX_MACS    64  max kernel taps (ker_row*ker_col) the engine accepts
//  MEM_LAT     1   BRAM read latency in cycles (rd_en -> rdata valid)
// PORTS
//  clk          in   1             clock, rising edge
//  rst          in   1             asynchronous reset, active-low
//  start        in   1             job request; sampled only in IDLE
//  img_row/img_col  in  ADDR_WIDTH each  image dims; latched on accepted start
//  ker_row/ker_col  in  ADDR_WIDTH each  kernel dims; latched on accepted start
//  busy         out  1             high from accepted start until done
//  done         out  1             1-cycle pulse, job complete
//  cfg_err      out  1             1-cycle pulse, start rejected (bad dims)
//  img_rd_en    out  1             feature BRAM read strobe
//  img_addr     out  ADDR_WIDTH    feature BRAM address
//  ker_rd_en    out  1             weight BRAM read strobe (same cycle as img_rd_en)
//  ker_addr     out  ADDR_WIDTH    weight BRAM address
//  img_rdata    in   DATA_WIDTH    feature read data
//  ker_rdata    in   DATA_WIDTH    weight read data
//  feed_valid   out  1             tap valid to engine (img_rd_en delayed MEM_LAT)
//  feed_data    out  DATA_WIDTH    tap data (= img_rdata)
//  feed_weight  out  DATA_WIDTH    tap weight (= ker_rdata)
//  res_valid    in   1             engine result strobe
//  res_data     in   2*DATA_WIDTH  engine result, signed
//  out_we       out  1             output buffer write strobe
//  out_addr     out  ADDR_WIDTH    output buffer address
//  out_data     out  2*DATA_WIDTH  output buffer data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0.
//   Reset asserted mid-job aborts immediately; no done pulse.
//  FSM states:
//   IDLE   -- start: cfg ok -> FEED, busy=1; bad cfg -> cfg_err pulse, stay IDLE.
//   FEED   -- issue K=ker_row*ker_col reads, one per cycle, kr outer, kc inner; after the last read -> WAIT.
//   WAIT   -- first res_valid: out_we=1, out_addr=orow*OC+ocol, out_data=res_data;
//             then advance ocol, and orow when ocol wraps.
//             If more windows -> FEED, else -> DONE.
//   DONE   -- done=1, busy=0 the same cycle -> IDLE.
//  Config is bad when any dim = 0, ker_row>img_row, ker_col>img_col, or K>MAX_MACS.
//  OR=img_row-ker_row+1 and OC=img_col-ker_col+1 are computed once, on accepted start.
//  Read addresses: img_addr=(orow+kr)*img_col+(ocol+kc); ker_addr=kr*ker_col+kc.
//   All products are truncated to ADDR_WIDTH.
//  feed_valid/feed_data/feed_weight come from a MEM_LAT-deep valid shift register.
//   Exactly K feed_valid cycles per window, contiguous.
//  res_valid outside WAIT is ignored. Only the first res_valid in WAIT is consumed.
//  start while busy is ignored. start coincident with DONE is ignored.
//  A new start is accepted no earlier than the cycle after done.
//  Window cost: K + MEM_LAT + engine latency + 1 cycle. Total writes = OR*OC.
// STRUCTURE
//  params.vh: state localparams (S_IDLE, S_FEED, S_WAIT, S_DONE, 2 bits).
//  Sub-module conv_addr_gen: holds the kr/kc/ocol/orow counters and address arithmetic.
//   Interface: step, next_win, last_tap, last_win.
//  The FSM and feed delay line stay in conv_scheduler.
// TESTING
//  4x4 img, 3x3 ker:
//   -> 4 windows, 9 reads each.
//   -> window(0,1) img_addr = 1,2,3,5,6,7,9,10,11.
//   -> out_addr 0,1,2,3; done after the 4th write.
//  ker 9x9 (K=81>64) or ker_row=0 -> cfg_err 1 cycle, busy stays 0, no reads.
//  3x3 img, 1x1 ker -> 9 windows, 1 feed per window, out_addr 0..8 in order.
//  start pulsed during FEED and during DONE -> ignored.
//   The next start after done is accepted.
//  rst low mid-FEED of a 4x4/2x2 job -> all outputs 0 at once, no done.
//   A fresh start then begins at img_addr 0.
//  Stray res_valid during FEED -> no out_we.
//   Two res_valid in WAIT -> exactly one write.

Source files
------------

// File: rtl/conv_scheduler_pkg.sv
// Shared types and default sizing for the convolution job scheduler.
package conv_scheduler_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 13;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_MACS   = 64;
  localparam int unsigned DEF_MEM_LAT    = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// Tap/window counters and the address arithmetic for image, kernel and output buffers.
module conv_addr_gen
  import conv_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  step,
  input  logic                  next_win,
  input  logic [ADDR_WIDTH-1:0] img_col,
  input  logic [ADDR_WIDTH-1:0] ker_row,
  input  logic [ADDR_WIDTH-1:0] ker_col,
  input  logic [ADDR_WIDTH-1:0] out_rows,
  input  logic [ADDR_WIDTH-1:0] out_cols,
  output logic                  last_tap,
  output logic                  last_win,
  output logic [ADDR_WIDTH-1:0] img_addr_c,
  output logic [ADDR_WIDTH-1:0] ker_addr_c,
  output logic [ADDR_WIDTH-1:0] out_addr_c
);

  localparam int unsigned AW = ADDR_WIDTH;

  logic [AW-1:0] kr, kc, orow, ocol;

  assign last_tap = (kr == ker_row - AW'(1)) && (kc == ker_col - AW'(1));
  assign last_win = (orow == out_rows - AW'(1)) && (ocol == out_cols - AW'(1));

  // Products wrap at the address width.
  assign img_addr_c = (orow + kr) * img_col + (ocol + kc);
  assign ker_addr_c = kr * ker_col + kc;
  assign out_addr_c = orow * out_cols + ocol;

  // kc is the inner tap loop, ocol the inner window loop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kr   <= '0;
      kc   <= '0;
      orow <= '0;
      ocol <= '0;
    end else if (clear) begin
      kr   <= '0;
      kc   <= '0;
      orow <= '0;
      ocol <= '0;
    end else begin
      if (step) begin
        if (kc == ker_col - AW'(1)) begin
          kc <= '0;
          kr <= last_tap ? '0 : kr + AW'(1);
        end else begin
          kc <= kc + AW'(1);
        end
      end
      if (next_win) begin
        if (ocol == out_cols - AW'(1)) begin
          ocol <= '0;
          orow <= last_win ? '0 : orow + AW'(1);
        end else begin
          ocol <= ocol + AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_scheduler.sv
// Job sequencer: streams kernel taps per output window into the engine and stores one result per window.
module conv_scheduler
  import conv_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_MACS   = DEF_MAX_MACS,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   img_row,
  input  logic [ADDR_WIDTH-1:0]   img_col,
  input  logic [ADDR_WIDTH-1:0]   ker_row,
  input  logic [ADDR_WIDTH-1:0]   ker_col,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic                    img_rd_en,
  output logic [ADDR_WIDTH-1:0]   img_addr,
  output logic                    ker_rd_en,
  output logic [ADDR_WIDTH-1:0]   ker_addr,
  input  logic [DATA_WIDTH-1:0]   img_rdata,
  input  logic [DATA_WIDTH-1:0]   ker_rdata,
  output logic                    feed_valid,
  output logic [DATA_WIDTH-1:0]   feed_data,
  output logic [DATA_WIDTH-1:0]   feed_weight,
  input  logic                    res_valid,
  input  logic [2*DATA_WIDTH-1:0] res_data,
  output logic                    out_we,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [2*DATA_WIDTH-1:0] out_data
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned RW = 2 * DATA_WIDTH;
  localparam int unsigned KW = 2 * ADDR_WIDTH;

  state_e        state, state_d;
  logic          busy_d, done_d, cfg_err_d, rd_en_d, out_we_d;
  logic [AW-1:0] img_addr_d, ker_addr_d, out_addr_d;
  logic [RW-1:0] out_data_d;
  logic          cfg_load_c, step_c, next_win_c;

  logic [AW-1:0] img_col_q, ker_row_q, ker_col_q, out_rows_q, out_cols_q;
  logic          last_tap, last_win;
  logic [AW-1:0] img_addr_c, ker_addr_c, out_addr_c;

  // Kernel size is checked at full product width so large dims cannot alias small.
  logic [KW-1:0] k_full_c;
  logic          cfg_ok_c;

  assign k_full_c = KW'(ker_row) * KW'(ker_col);
  assign cfg_ok_c = (img_row != '0) && (img_col != '0) &&
                    (ker_row != '0) && (ker_col != '0) &&
                    (ker_row <= img_row) && (ker_col <= img_col) &&
                    (k_full_c <= KW'(MAX_MACS));

  conv_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (cfg_load_c),
    .step      (step_c),
    .next_win  (next_win_c),
    .img_col   (img_col_q),
    .ker_row   (ker_row_q),
    .ker_col   (ker_col_q),
    .out_rows  (out_rows_q),
    .out_cols  (out_cols_q),
    .last_tap  (last_tap),
    .last_win  (last_win),
    .img_addr_c(img_addr_c),
    .ker_addr_c(ker_addr_c),
    .out_addr_c(out_addr_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d    = state;
    busy_d     = busy;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    rd_en_d    = 1'b0;
    img_addr_d = '0;
    ker_addr_d = '0;
    out_we_d   = 1'b0;
    out_addr_d = '0;
    out_data_d = '0;
    cfg_load_c = 1'b0;
    step_c     = 1'b0;
    next_win_c = 1'b0;
    case (state)
      S_IDLE: begin
        // The done cycle itself is not an accept slot.
        if (start && !done) begin
          if (cfg_ok_c) begin
            cfg_load_c = 1'b1;
            busy_d     = 1'b1;
            state_d    = S_FEED;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_FEED: begin
        step_c     = 1'b1;
        rd_en_d    = 1'b1;
        img_addr_d = img_addr_c;
        ker_addr_d = ker_addr_c;
        if (last_tap) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid) begin
          next_win_c = 1'b1;
          out_we_d   = 1'b1;
          out_addr_d = out_addr_c;
          out_data_d = res_data;
          state_d    = last_win ? S_DONE : S_FEED;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      img_rd_en <= 1'b0;
      img_addr  <= '0;
      ker_addr  <= '0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      cfg_err   <= cfg_err_d;
      img_rd_en <= rd_en_d;
      img_addr  <= img_addr_d;
      ker_addr  <= ker_addr_d;
      out_we    <= out_we_d;
      out_addr  <= out_addr_d;
      out_data  <= out_data_d;
    end
  end

  assign ker_rd_en = img_rd_en;

  // Job geometry, frozen for the whole job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_col_q  <= '0;
      ker_row_q  <= '0;
      ker_col_q  <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
    end else if (cfg_load_c) begin
      img_col_q  <= img_col;
      ker_row_q  <= ker_row;
      ker_col_q  <= ker_col;
      out_rows_q <= img_row - ker_row + AW'(1);
      out_cols_q <= img_col - ker_col + AW'(1);
    end
  end

  // Read strobe delayed by the BRAM latency marks when read data is valid.
  logic [MEM_LAT-1:0] vld_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= img_rd_en;
      for (int i = 1; i < int'(MEM_LAT); i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  assign feed_valid  = vld_sr[MEM_LAT-1];
  assign feed_data   = feed_valid ? img_rdata : '0;
  assign feed_weight = feed_valid ? ker_rdata : '0;

endmodule
